// File: rtl/fft8_stream.sv
// fft8_stream: streaming 8-point radix-2 DIT FFT/IFFT, transformed in place in a bit-reversed frame buffer.
// Optional macro FFT8_ROUND_EN: round half-up at the twiddle and stage shifts (default build truncates).
module fft8_stream #(
    parameter int DW  = 16,
    parameter int TWF = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 mode_ifft,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 out_sat
);

    localparam int PW = DW + 17;
    localparam int SW = DW + 2;
    localparam logic signed [SW-1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {3'b111, {(DW-1){1'b0}}};
`ifdef FFT8_ROUND_EN
    localparam logic signed [SW-1:0] HALF_S = SW'(1);
    localparam logic signed [PW-1:0] HALF_P = PW'(1) <<< (TWF - 1);
`endif

    typedef enum logic [2:0] {LOAD, S1, S2, S3, UNLOAD} state_t;

    typedef struct packed {
        logic signed [DW-1:0] top_re;
        logic signed [DW-1:0] top_im;
        logic signed [DW-1:0] bot_re;
        logic signed [DW-1:0] bot_im;
        logic                 sat;
    } bfly_t;

    function automatic logic signed [15:0] tw_re(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'sd16384;
            2'd1:    return 16'sd11585;
            2'd2:    return 16'sd0;
            default: return -16'sd11585;
        endcase
    endfunction

    function automatic logic signed [15:0] tw_im(input logic [1:0] idx, input logic inv);
        logic signed [15:0] w;
        case (idx)
            2'd0:    w = 16'sd0;
            2'd1:    w = -16'sd11585;
            2'd2:    w = -16'sd16384;
            default: w = -16'sd11585;
        endcase
        return inv ? -w : w;
    endfunction

    // Halve a butterfly sum and clamp it; the MSB of the result flags a clamp.
    function automatic logic [DW:0] scale_sat(input logic signed [SW-1:0] sum);
        logic signed [SW-1:0] half;
`ifdef FFT8_ROUND_EN
        half = (sum + HALF_S) >>> 1;
`else
        half = sum >>> 1;
`endif
        if (half > MAXV) return {1'b1, MAXV[DW-1:0]};
        if (half < MINV) return {1'b1, MINV[DW-1:0]};
        return {1'b0, half[DW-1:0]};
    endfunction

    function automatic bfly_t butterfly(
        input logic signed [DW-1:0] a_re,
        input logic signed [DW-1:0] a_im,
        input logic signed [DW-1:0] b_re,
        input logic signed [DW-1:0] b_im,
        input logic signed [15:0]   w_re,
        input logic signed [15:0]   w_im
    );
        logic signed [PW-1:0] mr;
        logic signed [PW-1:0] mi;
        logic signed [SW-1:0] pr;
        logic signed [SW-1:0] pi;
        logic [DW:0]          r0;
        logic [DW:0]          r1;
        logic [DW:0]          r2;
        logic [DW:0]          r3;
        bfly_t                r;
        mr = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        mi = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
`ifdef FFT8_ROUND_EN
        mr = mr + HALF_P;
        mi = mi + HALF_P;
`endif
        pr = SW'(mr >>> TWF);
        pi = SW'(mi >>> TWF);
        r0 = scale_sat(SW'(a_re) + pr);
        r1 = scale_sat(SW'(a_im) + pi);
        r2 = scale_sat(SW'(a_re) - pr);
        r3 = scale_sat(SW'(a_im) - pi);
        r.top_re = r0[DW-1:0];
        r.top_im = r1[DW-1:0];
        r.bot_re = r2[DW-1:0];
        r.bot_im = r3[DW-1:0];
        r.sat    = r0[DW] | r1[DW] | r2[DW] | r3[DW];
        return r;
    endfunction

    state_t               state;
    logic signed [DW-1:0] buf_re [8];
    logic signed [DW-1:0] buf_im [8];
    logic signed [DW-1:0] nxt_re [8];
    logic signed [DW-1:0] nxt_im [8];
    logic [2:0]           in_cnt;
    logic [2:0]           out_cnt;
    logic                 mode;
    logic                 sat_flag;
    logic                 stage_sat;

    // One shared set of 4 butterflies; the state picks span and twiddle addressing.
    always_comb begin
        logic [2:0] top;
        logic [2:0] bot;
        logic [1:0] twi;
        bfly_t      res;
        nxt_re    = buf_re;
        nxt_im    = buf_im;
        stage_sat = 1'b0;
        top       = '0;
        bot       = '0;
        twi       = '0;
        res       = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            case (state)
                S2: begin
                    top = {l[1], 1'b0, l[0]};
                    bot = {l[1], 1'b1, l[0]};
                    twi = {l[0], 1'b0};
                end
                S3: begin
                    top = {1'b0, l[1:0]};
                    bot = {1'b1, l[1:0]};
                    twi = l[1:0];
                end
                default: begin
                    top = {l[1:0], 1'b0};
                    bot = {l[1:0], 1'b1};
                    twi = 2'd0;
                end
            endcase
            res = butterfly(buf_re[top], buf_im[top], buf_re[bot], buf_im[bot],
                            tw_re(twi), tw_im(twi, mode));
            nxt_re[top] = res.top_re;
            nxt_im[top] = res.top_im;
            nxt_re[bot] = res.bot_re;
            nxt_im[bot] = res.bot_im;
            stage_sat   = stage_sat | res.sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_sat   <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            mode      <= 1'b0;
            sat_flag  <= 1'b0;
            buf_re    <= '{default: '0};
            buf_im    <= '{default: '0};
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        buf_re[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_re;
                        buf_im[{in_cnt[0], in_cnt[1], in_cnt[2]}] <= in_im;
                        if (in_cnt == 3'd0) mode <= mode_ifft;
                        in_cnt <= in_cnt + 3'd1;
                        if (in_cnt == 3'd7) begin
                            state    <= S1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S1, S2: begin
                    buf_re   <= nxt_re;
                    buf_im   <= nxt_im;
                    sat_flag <= sat_flag | stage_sat;
                    state    <= (state == S1) ? S2 : S3;
                end
                S3: begin
                    // Bin 0 is taken straight from the last stage so it is visible with out_valid.
                    buf_re    <= nxt_re;
                    buf_im    <= nxt_im;
                    sat_flag  <= sat_flag | stage_sat;
                    out_valid <= 1'b1;
                    out_re    <= nxt_re[0];
                    out_im    <= nxt_im[0];
                    out_sop   <= 1'b1;
                    out_eop   <= 1'b0;
                    out_sat   <= sat_flag | stage_sat;
                    out_cnt   <= '0;
                    state     <= UNLOAD;
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (out_cnt == 3'd7) begin
                            state     <= LOAD;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_re    <= '0;
                            out_im    <= '0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            out_sat   <= 1'b0;
                            sat_flag  <= 1'b0;
                            out_cnt   <= '0;
                        end else begin
                            out_cnt <= out_cnt + 3'd1;
                            out_re  <= buf_re[out_cnt + 3'd1];
                            out_im  <= buf_im[out_cnt + 3'd1];
                            out_sop <= 1'b0;
                            out_eop <= (out_cnt == 3'd6);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream: directed frames with hand-computed bins for the default (truncating) build of fft8_stream.
module tb_fft8_stream;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 mode_ifft;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_sop;
    logic                 out_eop;
    logic                 out_sat;

    int checks = 0;
    int errors = 0;

    fft8_stream #(.DW(DW), .TWF(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .mode_ifft (mode_ifft),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_in_ready"},  int'(in_ready), 1);
        check({name, "_out_re"},    int'(out_re), 0);
        check({name, "_out_im"},    int'(out_im), 0);
        check({name, "_out_sop"},   int'(out_sop), 0);
        check({name, "_out_eop"},   int'(out_eop), 0);
        check({name, "_out_sat"},   int'(out_sat), 0);
    endtask

    // toggle=1 flips mode_ifft on every later sample so only the first one may be latched.
    task automatic send_frame(input int re[8], input int im[8], input logic m, input bit toggle);
        int   n;
        int   guard;
        logic hs;
        n = 0;
        guard = 0;
        while (n < 8 && guard < 40) begin
            @(negedge clk);
            guard++;
            in_valid  = 1'b1;
            in_re     = 16'(re[n]);
            in_im     = 16'(im[n]);
            mode_ifft = (n == 0 || !toggle) ? m : (n[0] ? ~m : m);
            hs = in_ready;
            @(posedge clk);
            if (hs) n++;
        end
        if (n < 8) check("load_timeout", n, 8);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv_frame(input string name, input int ere[8], input int eim[8], input int esat,
                              input int stall_bin, input int stop_at);
        int   got;
        int   wait_n;
        int   stalls;
        int   guard;
        logic seen;
        got = 0;
        wait_n = 0;
        stalls = 0;
        guard = 0;
        seen = 1'b0;
        out_ready = 1'b1;
        while (got < stop_at && guard < 60) begin
            @(negedge clk);
            guard++;
            check($sformatf("%s_in_ready_low", name), int'(in_ready), 0);
            if (!seen) begin
                wait_n++;
                if (out_valid) begin
                    seen = 1'b1;
                    check($sformatf("%s_latency", name), wait_n, 4);
                end else begin
                    check($sformatf("%s_idle_re", name), int'(out_re), 0);
                end
            end
            if (out_valid) begin
                out_ready = (got == stall_bin && stalls < 3) ? 1'b0 : 1'b1;
                check($sformatf("%s_bin%0d_re", name, got),  int'(out_re),  ere[got]);
                check($sformatf("%s_bin%0d_im", name, got),  int'(out_im),  eim[got]);
                check($sformatf("%s_bin%0d_sop", name, got), int'(out_sop), (got == 0) ? 1 : 0);
                check($sformatf("%s_bin%0d_eop", name, got), int'(out_eop), (got == 7) ? 1 : 0);
                check($sformatf("%s_bin%0d_sat", name, got), int'(out_sat), esat);
                if (out_ready) got++;
                else stalls++;
            end
        end
        if (got < stop_at) check($sformatf("%s_unload_timeout", name), got, stop_at);
        if (stall_bin >= 0 && stop_at > stall_bin) check($sformatf("%s_stall_cycles", name), stalls, 3);
    endtask

    task automatic frame_end(input string name);
        @(negedge clk);
        check_idle({name, "_end"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x_re [8];
        int x_im [8];
        int e_re [8];
        int e_im [8];

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        mode_ifft = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        x_re = '{1000, 0, 0, 0, 0, 0, 0, 0};
        x_im = '{default: 0};
        e_re = '{default: 125};
        e_im = '{default: 0};
        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("impulse", e_re, e_im, 0, -1, 8);
        frame_end("impulse");

        x_re = '{default: 800};
        e_re = '{800, 0, 0, 0, 0, 0, 0, 0};
        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("const", e_re, e_im, 0, -1, 8);
        frame_end("const");

        x_re = '{0, 8000, 0, 0, 0, 0, 0, 0};
        e_re = '{1000, 707, 0, -708, -1000, -707, 0, 707};
        e_im = '{0, -708, -1000, -708, 0, 707, 1000, 707};
        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("shift_fft", e_re, e_im, 0, -1, 8);
        frame_end("shift_fft");

        x_re = '{32767, 32767, 0, -32768, -32768, -32768, 0, 32767};
        x_im = '{0, 32767, 32767, 32767, 0, -32768, -32768, -32768};
        e_re = '{-1, 32767, -1, -1, 0, -6786, -1, 0};
        e_im = '{-1, 0, 0, 0, 0, 0, 0, 0};
        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("sat", e_re, e_im, 1, -1, 8);
        frame_end("sat");

        x_re = '{0, 8000, 0, 0, 0, 0, 0, 0};
        x_im = '{default: 0};
        e_re = '{1000, 707, 0, -708, -1000, -707, 0, 707};
        e_im = '{0, 707, 1000, 707, 0, -707, -1000, -707};
        send_frame(x_re, x_im, 1'b1, 1'b1);
        recv_frame("ifft_bp", e_re, e_im, 0, 3, 8);
        frame_end("ifft_bp");

        x_re = '{1000, 0, 0, 0, 0, 0, 0, 0};
        e_re = '{default: 125};
        e_im = '{default: 0};
        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("rst_mid", e_re, e_im, 0, -1, 5);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle("rst_async");
        @(negedge clk);
        rst = 1'b1;

        send_frame(x_re, x_im, 1'b0, 1'b0);
        recv_frame("post_rst", e_re, e_im, 0, -1, 8);
        frame_end("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft8_stream.md
# fft8_stream

Streaming 8-point radix-2 DIT FFT/IFFT engine for the baseband modulator's IFFT processor. Natural-order complex samples come in one per cycle over a valid/ready handshake. Each frame is transformed in place in a bit-reversed frame buffer, one registered stage per cycle, with per-stage 1/2 scaling. Results leave in natural order with frame markers and output backpressure. The block extends the fixed parallel 8-point core with parametrised width, selectable FFT/IFFT mode, overflow saturation and a handshaked serial interface.

## Interface
- DW, 16: sample component width, signed two's complement.
- TWF, 14: twiddle fraction bits. Twiddles are Q2.TWF, 16-bit, so 1.0 = 16384.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample; high only in LOAD.
- in_re, in_im  in  DW each  input sample, signed.
- mode_ifft  in  1  0 = forward FFT, 1 = inverse; sampled with the first sample of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_re, out_im  out  DW each  output bin, signed; 0 whenever out_valid=0.
- out_sop, out_eop  out  1 each  high with bin 0 and bin 7 respectively, qualified by out_valid.
- out_sat  out  1  high throughout the frame's output if any saturation occurred in that frame.

## Operation
- States and transitions:
  - LOAD -> S1 on the 8th input handshake.
  - S1 -> S2 -> S3 unconditionally, one cycle each.
  - S3 -> UNLOAD.
  - UNLOAD -> LOAD on the out_eop handshake.
- LOAD:
  - 3-bit in_cnt counts accepted samples.
  - Sample n is written to buffer address bitrev(n).
  - mode is latched when in_cnt=0 and a handshake occurs; mode_ifft is ignored for the rest of the frame.
- Stage s (s=1,2,3, span 2^(s-1)) runs all 4 butterflies on the buffer in one cycle and writes back.
- Twiddle index k·(4>>(s-1)), with k the position within the group. Table: W0=16384+j0, W1=11585−j11585, W2=0−j16384, W3=−11585−j11585. IFFT negates the imaginary part.
- Butterfly arithmetic:
  - p = b·W as a full-precision complex product, reduced by >>TWF.
  - a' = (a+p)>>1 and b' = (a−p)>>1, with sums computed at DW+2 bits and arithmetic shifts.
  - Each result saturates to [−2^(DW−1), 2^(DW−1)−1].
  - Any saturating clamp sets the frame's sat flag.
- The net transform is X[k] = (1/8)·Σ x[n]·W8^(±nk). The IFFT therefore also carries 1/8, so no extra scaling is applied.
- UNLOAD:
  - 3-bit out_cnt presents bins 0..7 in natural order.
  - Advances only on out_valid & out_ready.
  - The output sample and markers hold stable while out_ready=0.
- in_valid is ignored outside LOAD. Backpressure never drops or duplicates samples.

## Timing
- Reset values: state LOAD, in_ready=1, out_valid=0, out_re=out_im=0, out_sop=out_eop=out_sat=0, counters 0, mode 0, sat flag 0.
- Latency: the 8th input handshake occurs at edge T. S1, S2 and S3 compute at edges T+1, T+2 and T+3. out_valid rises after edge T+3, so the first output bin is visible 4 cycles after edge T.
- in_ready falls in the cycle after the 8th handshake and stays low until the cycle after the out_eop handshake.
- Throughput: one frame per 8 + 3 + 8 cycles minimum; frames do not overlap.
- Reset asserted mid-frame, in any state, discards the frame immediately and all outputs take their reset values asynchronously. The first frame after reset release is computed correctly.
- The sat flag clears when entering LOAD.

## Configuration
- FFT8_ROUND_EN defined: both the >>TWF product reduction and the >>1 stage scaling round half-up (add 2^(shift−1) before shifting).
- FFT8_ROUND_EN undefined: both shifts truncate toward −∞.
- Saturation applies in both builds.

## Test plan
- FFT impulse at origin: x0=1000, others 0, mode 0 -> all 8 bins 125+j0; out_sop on bin 0, out_eop on bin 7; out_sat=0.
- FFT constant input: all x=800+j0 -> X0=800, X1..X7 = 0 (±1 LSB without FFT8_ROUND_EN).
- Shifted impulse: x1=8000, others 0 -> FFT gives X0=1000, X2=0−j1000, X4=−1000, X6=0+j1000. IFFT gives X2=0+j1000 and X6=0−j1000 (±1 LSB).
- Saturation:
  - Stimulus: x0=32767+j0, x4=−32768+j0 with x1..x3, x5..x7 at full-scale values chosen so a stage-2/3 sum exceeds range.
  - Required: saturated bins clamp to 32767 or −32768, and out_sat stays high for all 8 bins of that frame.
- Backpressure and mode latch:
  - Stimulus: hold out_ready=0 for 3 cycles at bin 3; toggle mode_ifft mid-LOAD.
  - Required: bin 3 holds stable, no bins are lost or repeated, in_ready stays low, and the result matches the mode sampled with the first sample.
- Reset mid-UNLOAD:
  - Stimulus: assert rst after bin 4.
  - Required: out_valid=0 and in_ready=1 immediately; the next impulse frame yields all bins 125.
